// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Central pipeline sequencer for the five-stage core. It sits beside the
//   PC unit and the IF/ID and ID/EX registers. It decides, every cycle,
//   whether the front end advances, which pipeline registers are cleared,
//   and when an exception is taken. The priority order, highest first, is:
//   memory wait state, exception, divide issue, load-use hazard, taken branch.
//   It also counts the cycles in which the PC was held.
//
// State table
//   state    | meaning
//   RUN      | normal flow; all events are evaluated by priority
//   DIV_WAIT | front end frozen while a multi-cycle divide completes
//   MEM_WAIT | whole front end frozen until the MEM bus access completes
//
// Ports
//   cpu_clk       core clock; all state changes on the rising edge
//   reset         synchronous, active-high
//   ID_rs/ID_rt   source register fields of the instruction in ID
//   ID_uses_rt    the ID instruction reads rt
//   EX_MemRead    the instruction in EX is a load
//   EX_rt         destination register of the load in EX
//   branch_taken  branch/jump resolved taken in ID
//   div_start     a divide issues from EX this cycle
//   mem_req       MEM stage bus access active
//   mem_ready     bus access completes this cycle
//   exc_req       exception/interrupt request, held until acknowledged
//   PCWrite       PC and IF/ID load enable
//   IDEX_write    ID/EX load enable
//   IFID_flush    clear IF/ID
//   IDEX_flush    clear ID/EX (insert a bubble)
//   EXMEM_flush   clear EX/MEM
//   exc_ack       exception taken; the PC loads the vector on this edge
//   div_cancel    abort the in-flight divide
//   stall_count   cycles with PCWrite=0, wraps at 2^32
module hazard_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_rt,
  input  logic        branch_taken,
  input  logic        div_start,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        exc_req,
  output logic        PCWrite,
  output logic        IDEX_write,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        EXMEM_flush,
  output logic        exc_ack,
  output logic        div_cancel,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // The counter is loaded with DIV_CYCLES-1 on issue and the front end stays
  // frozen through the terminal count of zero, giving DIV_CYCLES frozen cycles.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
  logic             load_use;
  logic             run_evt;

  // r0 is hardwired to zero, so a load targeting it can never cause a hazard.
  assign load_use = EX_MemRead && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

  always_comb begin
    PCWrite     = 1'b1;
    IDEX_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    exc_ack     = 1'b0;
    div_cancel  = 1'b0;
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    run_evt     = 1'b0;

    if (reset) begin
      // During the reset cycle the pipeline is released, whatever state was held.
      state_nxt   = ST_RUN;
      div_cnt_nxt = '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            // A pending exception is deferred here. The requester keeps
            // exc_req high until exc_ack is returned.
            PCWrite    = 1'b0;
            IDEX_write = 1'b0;
            state_nxt  = ST_MEM_WAIT;
          end else begin
            run_evt = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          if (!mem_ready) begin
            PCWrite    = 1'b0;
            IDEX_write = 1'b0;
          end else begin
            // The access completes this cycle, so the lower RUN priorities apply now.
            state_nxt = ST_RUN;
            run_evt   = 1'b1;
          end
        end

        ST_DIV_WAIT: begin
          if (exc_req) begin
            // Abandon the divide and take the exception immediately.
            PCWrite     = 1'b1;
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            exc_ack     = 1'b1;
            div_cancel  = 1'b1;
            state_nxt   = ST_RUN;
            div_cnt_nxt = '0;
          end else begin
            PCWrite    = 1'b0;
            IDEX_write = 1'b0;
            if (div_cnt == '0) begin
              state_nxt = ST_RUN;
            end else begin
              div_cnt_nxt = div_cnt - CNT_ONE;
            end
          end
        end

        default: begin
          state_nxt   = ST_RUN;
          div_cnt_nxt = '0;
        end
      endcase

      if (run_evt) begin
        if (exc_req) begin
          IFID_flush  = 1'b1;
          IDEX_flush  = 1'b1;
          EXMEM_flush = 1'b1;
          exc_ack     = 1'b1;
          state_nxt   = ST_RUN;
        end else if (div_start) begin
          // The issue cycle itself still advances the front end.
          state_nxt   = ST_DIV_WAIT;
          div_cnt_nxt = DIV_LOAD;
        end else if (load_use) begin
          // Hold PC and IF/ID and push one bubble into ID/EX. A taken branch
          // in the same cycle is ignored; it resolves again next cycle.
          PCWrite    = 1'b0;
          IDEX_flush = 1'b1;
        end else if (branch_taken) begin
          IFID_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state       <= ST_RUN;
      div_cnt     <= '0;
      stall_count <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      if (!PCWrite) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencer for the five-stage core.
- Drives PCWrite (PC and IF/ID load enable), IF/ID / ID/EX / EX/MEM flush, and ID/EX write enable.
- Resolves load-use hazards, taken branches, multi-cycle divide stalls, memory wait states and exceptions under one fixed priority scheme.
- Sits beside the IF/ID and ID/EX registers and the PC unit; carries a stall-cycle performance counter.

Parameters:
DIV_CYCLES, 32, cycles the front end is frozen after a divide issues (min 1)
CNT_W, 6, divide-counter width; must satisfy 2^CNT_W > DIV_CYCLES-1

Ports:
cpu_clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high
ID_rs  in  5  rs field of instruction in ID
ID_rt  in  5  rt field of instruction in ID
ID_uses_rt  in  1  ID instruction reads rt
EX_MemRead  in  1  instruction in EX is a load
EX_rt  in  5  load destination register in EX
branch_taken  in  1  branch/jump resolved taken in ID
div_start  in  1  divide issuing from EX this cycle
mem_req  in  1  MEM stage bus access active
mem_ready  in  1  bus access completes this cycle
exc_req  in  1  exception/interrupt request
PCWrite  out  1  PC and IF/ID load enable
IDEX_write  out  1  ID/EX load enable
IFID_flush  out  1  clear IF/ID
IDEX_flush  out  1  clear ID/EX (insert bubble)
EXMEM_flush  out  1  clear EX/MEM
exc_ack  out  1  exception taken; PC loads vector this edge
div_cancel  out  1  abort in-flight divide
stall_count  out  32  cycles with PCWrite=0, wraps at 2^32

Behaviour:
- State register: RUN, DIV_WAIT, MEM_WAIT, plus a CNT_W-bit divide counter.
- Control outputs are combinational from the current state and inputs. stall_count is registered.
- Reset: state=RUN, counter=0, stall_count=0.
- Reset-cycle outputs: PCWrite=1, IDEX_write=1, all flushes=0, exc_ack=0, div_cancel=0.
- Reset mid-stall returns to RUN with no pending events retained.
- Default in RUN with no events: PCWrite=1, IDEX_write=1, all flushes=0.
- Load-use hazard = EX_MemRead && EX_rt!=0 && (EX_rt==ID_rs || (ID_uses_rt && EX_rt==ID_rt)).
- RUN priority, highest first:
  1. Memory wait: mem_req && !mem_ready -> PCWrite=0, IDEX_write=0, no flushes, next=MEM_WAIT. A simultaneous exc_req is deferred, not dropped; the requester holds exc_req.
  2. Exception: exc_req -> PCWrite=1, IFID_flush=IDEX_flush=EXMEM_flush=1, exc_ack=1, next=RUN.
  3. Divide issue: div_start -> PCWrite=1 that cycle, next=DIV_WAIT, counter<=DIV_CYCLES-1.
  4. Load-use: PCWrite=0, IDEX_write=1, IDEX_flush=1 (one bubble). The stall wins over branch_taken in the same cycle; the branch re-resolves next cycle.
  5. Taken branch: PCWrite=1, IFID_flush=1.
- DIV_WAIT:
  - PCWrite=0, IDEX_write=0, no flushes.
  - counter==0 -> next=RUN; else decrement.
  - Total frozen cycles = DIV_CYCLES exactly.
  - exc_req in DIV_WAIT: div_cancel=1, exc_ack=1, all three flushes=1, PCWrite=1, next=RUN, counter<=0.
- MEM_WAIT:
  - mem_ready=0: PCWrite=0, IDEX_write=0, no flushes, stay.
  - mem_ready=1: outputs as RUN with no memory-wait event; exc_req may be taken this cycle (RUN priorities 2-5 apply); next=RUN.
- stall_count increments on every edge where PCWrite=0 and reset=0.
- Guarantees:
  - Flushes never assert while PCWrite=0, except the load-use IDEX_flush.
  - exc_ack is asserted for exactly one cycle per accepted request.

Test Plan:
1. Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 for 1 cycle -> PCWrite=0, IDEX_flush=1 that cycle; stall_count 0->1. Repeat with EX_rt=0 -> no stall.
2. Branch and load-use together: branch_taken=1 with the hazard -> IFID_flush=0, PCWrite=0. Next cycle, hazard gone and branch_taken=1 -> IFID_flush=1, PCWrite=1.
3. Divide with DIV_CYCLES=4: div_start pulse -> PCWrite=1 on issue, then PCWrite=0 for exactly 4 cycles, then 1; stall_count=4.
4. Exception during DIV_WAIT (cycle 2 of 4): exc_req=1 -> exc_ack=1, div_cancel=1, all flushes=1 in the same cycle; RUN next cycle, PCWrite=1.
5. Memory wait plus exception: mem_req=1, mem_ready=0 for 3 cycles with exc_req held -> frozen 3 cycles, exc_ack=0. The cycle mem_ready=1 -> exc_ack=1, flushes=1.
6. Reset asserted during MEM_WAIT -> next cycle RUN, PCWrite=1, stall_count=0, all flushes=0.
